// File: rtl/spi_bus_scheduler_pkg.sv
// Shared types and constants for the SPI bus scheduler and its byte shifter.
package spi_bus_scheduler_pkg;

    // Default SCK half-period in enabled CLK cycles
    localparam int SPI_DEFAULT_DIV = 2;

    // Scheduler states; the encodings are fixed so they stay aligned with the top-level header
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_DESELECT = 2'd3
    } sched_state_t;

    // What the shifter should do when it is started
    typedef enum logic [1:0] {
        OP_LEAD_SHIFT = 2'd0,  // one idle half-period with SCK low, then 16 shift half-periods
        OP_SHIFT      = 2'd1,  // 16 shift half-periods straight away (locked follow-on byte)
        OP_GAP        = 2'd2   // one half-period with MOSI high, no SCK activity
    } shift_op_t;

    // Shifter internal phase
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LEAD = 2'd1,
        PH_BITS = 2'd2,
        PH_GAP  = 2'd3
    } shift_phase_t;

    // Bus owner; the numeric value doubles as the requester index
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // One requester's byte-level request
    typedef struct packed {
        logic       req;
        logic       hold;
        logic [7:0] txd;
    } byte_req_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_A) ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine: half-period timing, SCK/MOSI generation and MISO capture.
// Also times the lead-in and deselect half-periods so the parent needs no counter of its own.
module spi_byte_shifter
    import spi_bus_scheduler_pkg::*;
#(
    parameter int DIV = SPI_DEFAULT_DIV
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       CLK_en,
    input  logic       start,
    input  shift_op_t  op,
    input  logic [7:0] txd,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] rxd,
    output logic       hp_end,
    output logic       done
);

    localparam logic [7:0] HP_LAST = 8'(DIV - 1);

    shift_phase_t phase;
    logic [7:0]   hcnt;
    logic [3:0]   bcnt;
    logic [7:0]   sreg;

    // hp_end marks the enabled cycle that closes the current half-period
    assign hp_end = CLK_en && (phase != PH_IDLE) && (hcnt == HP_LAST);
    assign done   = hp_end && (phase == PH_BITS) && (bcnt == 4'd15);
    assign rxd    = sreg;

    // Half-period sequencing; even half-period ends raise SCK and sample MISO, odd ones drop SCK and present the next bit
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            phase <= PH_IDLE;
            hcnt  <= 8'd0;
            bcnt  <= 4'd0;
            sreg  <= 8'd0;
            sck   <= 1'b0;
            mosi  <= 1'b1;
        end else if (CLK_en) begin
            if (start) begin
                hcnt <= 8'd0;
                bcnt <= 4'd0;
                sck  <= 1'b0;
                case (op)
                    OP_LEAD_SHIFT: phase <= PH_LEAD;
                    OP_SHIFT:      phase <= PH_BITS;
                    default:       phase <= PH_GAP;
                endcase
                if (op == OP_GAP) begin
                    mosi <= 1'b1;
                end else begin
                    sreg <= txd;
                    mosi <= txd[7];
                end
            end else if (phase != PH_IDLE) begin
                if (hcnt != HP_LAST) begin
                    hcnt <= hcnt + 8'd1;
                end else begin
                    hcnt <= 8'd0;
                    case (phase)
                        PH_LEAD: phase <= PH_BITS;
                        PH_GAP:  phase <= PH_IDLE;
                        PH_BITS: begin
                            bcnt <= bcnt + 4'd1;
                            if (!bcnt[0]) begin
                                sck  <= 1'b1;
                                sreg <= {sreg[6:0], miso};
                            end else begin
                                sck  <= 1'b0;
                                mosi <= sreg[7];
                            end
                            // Last falling edge: nothing left to send, park MOSI high
                            if (bcnt == 4'd15) begin
                                phase <= PH_IDLE;
                                mosi  <= 1'b1;
                            end
                        end
                        default: phase <= PH_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/spi_bus_scheduler.sv
// Two-requester SPI bus scheduler: per-byte round-robin arbitration, locked bursts and SD chip select.
// Bit timing lives in spi_byte_shifter; this level owns grant, lock, nCS and the ACK/RXD handback.
module spi_bus_scheduler
    import spi_bus_scheduler_pkg::*;
#(
    parameter int DIV = SPI_DEFAULT_DIV
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       CLK_en,
    input  logic       A_REQ,
    input  logic       B_REQ,
    input  logic       A_HOLD,
    input  logic       B_HOLD,
    input  logic [7:0] A_TXD,
    input  logic [7:0] B_TXD,
    output logic [7:0] A_RXD,
    output logic [7:0] B_RXD,
    output logic       A_ACK,
    output logic       B_ACK,
    output logic       BUSY,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       nCS
);

    byte_req_t [1:0] rq;
    sched_state_t    state;
    owner_t          owner;
    owner_t          prio;
    owner_t          grant_sel;
    logic            lock;

    logic            sh_start;
    shift_op_t       sh_op;
    logic [7:0]      sh_txd;
    logic [7:0]      sh_rxd;
    logic            sh_hp_end;
    logic            sh_done;

    assign rq[0] = '{req: A_REQ, hold: A_HOLD, txd: A_TXD};
    assign rq[1] = '{req: B_REQ, hold: B_HOLD, txd: B_TXD};

    // The bus counts as busy while a transfer runs or while a burst keeps it locked
    assign BUSY = (state != ST_IDLE) || lock;

    // Arbitration winner and shifter kick-off for the current enabled cycle
    always_comb begin
        grant_sel = prio;
        if (rq[0].req && !rq[1].req) begin
            grant_sel = OWN_A;
        end else if (rq[1].req && !rq[0].req) begin
            grant_sel = OWN_B;
        end
        sh_start = 1'b0;
        sh_op    = OP_SHIFT;
        sh_txd   = rq[owner].txd;
        if (CLK_en) begin
            case (state)
                ST_IDLE: begin
                    if (!lock) begin
                        if (rq[0].req || rq[1].req) begin
                            sh_start = 1'b1;
                            sh_op    = OP_LEAD_SHIFT;
                            sh_txd   = rq[grant_sel].txd;
                        end
                    end else if (rq[owner].req) begin
                        // A pending request beats a simultaneous HOLD release
                        sh_start = 1'b1;
                        sh_op    = OP_SHIFT;
                    end else if (!rq[owner].hold) begin
                        sh_start = 1'b1;
                        sh_op    = OP_GAP;
                    end
                end
                ST_SHIFT: begin
                    if (sh_done && !rq[owner].hold) begin
                        sh_start = 1'b1;
                        sh_op    = OP_GAP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scheduler FSM with registered nCS, ACK and RXD; ACK is cleared every CLK so it never stretches
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= ST_IDLE;
            owner <= OWN_A;
            prio  <= OWN_A;
            lock  <= 1'b0;
            nCS   <= 1'b1;
            A_ACK <= 1'b0;
            B_ACK <= 1'b0;
            A_RXD <= 8'h00;
            B_RXD <= 8'h00;
        end else begin
            A_ACK <= 1'b0;
            B_ACK <= 1'b0;
            if (CLK_en) begin
                case (state)
                    ST_IDLE: begin
                        if (!lock) begin
                            if (rq[0].req || rq[1].req) begin
                                owner <= grant_sel;
                                prio  <= other_owner(grant_sel);
                                nCS   <= 1'b0;
                                state <= ST_SETUP;
                            end
                        end else if (rq[owner].req) begin
                            state <= ST_SHIFT;
                        end else if (!rq[owner].hold) begin
                            lock  <= 1'b0;
                            nCS   <= 1'b1;
                            state <= ST_DESELECT;
                        end
                    end
                    ST_SETUP: begin
                        if (sh_hp_end) state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (sh_done) begin
                            lock <= rq[owner].hold;
                            if (owner == OWN_A) begin
                                A_ACK <= 1'b1;
                                A_RXD <= sh_rxd;
                            end else begin
                                B_ACK <= 1'b1;
                                B_RXD <= sh_rxd;
                            end
                            if (rq[owner].hold) begin
                                state <= ST_IDLE;
                            end else begin
                                nCS   <= 1'b1;
                                state <= ST_DESELECT;
                            end
                        end
                    end
                    ST_DESELECT: begin
                        if (sh_hp_end) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    spi_byte_shifter #(.DIV(DIV)) u_shifter (
        .CLK    (CLK),
        .nRESET (nRESET),
        .CLK_en (CLK_en),
        .start  (sh_start),
        .op     (sh_op),
        .txd    (sh_txd),
        .miso   (MISO),
        .sck    (SCK),
        .mosi   (MOSI),
        .rxd    (sh_rxd),
        .hp_end (sh_hp_end),
        .done   (sh_done)
    );

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Directed bench for spi_bus_scheduler: a vector table of single bytes plus hand-written
// sequences for arbitration order, locked bursts, hold release and mid-byte reset.
`timescale 1ns/1ps
module tb_spi_bus_scheduler;

    localparam int DIV = 2;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       CLK_en;
    logic       A_REQ = 1'b0, B_REQ = 1'b0, A_HOLD = 1'b0, B_HOLD = 1'b0;
    logic [7:0] A_TXD = 8'h00, B_TXD = 8'h00;
    logic [7:0] A_RXD, B_RXD;
    logic       A_ACK, B_ACK, BUSY, SCK, MOSI, MISO, nCS;

    int miso_mode = 0;   // 0: loop MOSI back, 1: tie low, 2: tie high
    bit sparse    = 1'b0;
    int en_ph     = 0;
    int cyc       = 0;
    int n_vec     = 0;
    int n_err     = 0;

    typedef struct {
        bit         is_b;
        bit         sp;
        logic [7:0] tx;
        int         mm;
        logic [7:0] exp_rx;
        int         exp_lat;
    } vec_t;
    vec_t vt[8];

    spi_bus_scheduler #(.DIV(DIV)) dut (
        .CLK(CLK), .nRESET(nRESET), .CLK_en(CLK_en),
        .A_REQ(A_REQ), .B_REQ(B_REQ), .A_HOLD(A_HOLD), .B_HOLD(B_HOLD),
        .A_TXD(A_TXD), .B_TXD(B_TXD), .A_RXD(A_RXD), .B_RXD(B_RXD),
        .A_ACK(A_ACK), .B_ACK(B_ACK), .BUSY(BUSY),
        .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .nCS(nCS)
    );

    always #10 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    assign MISO = (miso_mode == 0) ? MOSI : (miso_mode == 1) ? 1'b0 : 1'b1;

    // Enable is either always on or every third CLK, changed away from the active edge
    always @(negedge CLK) begin
        en_ph  = (en_ph == 2) ? 0 : en_ph + 1;
        CLK_en = !sparse || (en_ph == 0);
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRESET = 1'b0;
        A_REQ = 1'b0; B_REQ = 1'b0; A_HOLD = 1'b0; B_HOLD = 1'b0;
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && BUSY; k++) @(negedge CLK);
    endtask

    // One unlocked byte; latency counts CLK edges from the nCS-falling (grant) edge to the ACK edge
    task automatic run_byte(input bit is_b, input logic [7:0] tx, output int lat, output logic [7:0] rx,
                            output int rises, output int ack_w, output int other_acks);
        int   g, a;
        logic ps;
        g = -1; a = -1; rises = 0; ack_w = 0; other_acks = 0; rx = 8'h00; lat = -1;
        @(negedge CLK);
        ps = SCK;
        if (is_b) begin B_TXD = tx; B_REQ = 1'b1; end
        else      begin A_TXD = tx; A_REQ = 1'b1; end
        for (int k = 0; k < 400 && a < 0; k++) begin
            @(negedge CLK);
            if (g < 0 && !nCS) g = cyc;
            if (SCK && !ps) rises++;
            ps = SCK;
            if (is_b ? A_ACK : B_ACK) other_acks++;
            if (is_b ? B_ACK : A_ACK) begin
                a = cyc;
                rx = is_b ? B_RXD : A_RXD;
                A_REQ = 1'b0; B_REQ = 1'b0;
            end
        end
        if (a >= 0 && g >= 0) begin
            lat = a - g;
            @(negedge CLK);
            ack_w = 1 + int'(is_b ? B_ACK : A_ACK);
        end
        wait_idle();
    endtask

    initial begin
        int         lat, rises, ack_w, oth, n_ack, gap, min_gap, na, b_early, tb_ack;
        int         ncs_hi, busy_lo, viol, k;
        int         order[3], t_ack[3];
        logic [7:0] rx, brx;
        logic [7:0] rxs[3];
        bit         started, reached;
        logic       ps;

        //            is_b  sp    tx     mm  exp_rx  lat
        vt[0] = '{1'b0, 1'b0, 8'hA5, 0, 8'hA5,  34};
        vt[1] = '{1'b1, 1'b0, 8'h3C, 0, 8'h3C,  34};
        vt[2] = '{1'b0, 1'b0, 8'h5A, 1, 8'h00,  34};
        vt[3] = '{1'b1, 1'b0, 8'h96, 2, 8'hFF,  34};
        vt[4] = '{1'b0, 1'b0, 8'h00, 2, 8'hFF,  34};
        vt[5] = '{1'b1, 1'b0, 8'hFF, 1, 8'h00,  34};
        vt[6] = '{1'b0, 1'b1, 8'h5A, 0, 8'h5A, 102};
        vt[7] = '{1'b1, 1'b1, 8'h81, 0, 8'h81, 102};

        // Reset values, sampled while reset is still asserted
        repeat (3) @(negedge CLK);
        check("rst_sck",  int'(SCK),   0);
        check("rst_mosi", int'(MOSI),  1);
        check("rst_ncs",  int'(nCS),   1);
        check("rst_busy", int'(BUSY),  0);
        check("rst_aack", int'(A_ACK), 0);
        check("rst_back", int'(B_ACK), 0);
        check("rst_arxd", int'(A_RXD), 0);
        check("rst_brxd", int'(B_RXD), 0);
        nRESET = 1'b1;
        @(negedge CLK);

        // Table of single bytes
        for (int i = 0; i < 8; i++) begin
            sparse = vt[i].sp;
            miso_mode = vt[i].mm;
            repeat (4) @(negedge CLK);
            run_byte(vt[i].is_b, vt[i].tx, lat, rx, rises, ack_w, oth);
            check($sformatf("v%0d_rxd", i),   int'(rx), int'(vt[i].exp_rx));
            check($sformatf("v%0d_lat", i),   lat,      vt[i].exp_lat);
            check($sformatf("v%0d_sck", i),   rises,    8);
            check($sformatf("v%0d_ackw", i),  ack_w,    1);
            check($sformatf("v%0d_other", i), oth,      0);
            check($sformatf("v%0d_idle", i),  int'(BUSY), 0);
        end
        sparse = 1'b0;
        miso_mode = 0;

        // Simultaneous requests: A first, then B (A re-requests but PRIO now favours B), then A again
        do_reset();
        A_TXD = 8'h3C; B_TXD = 8'hC3; A_REQ = 1'b1; B_REQ = 1'b1;
        n_ack = 0; gap = 0; min_gap = 1000;
        order = '{9, 9, 9}; rxs = '{8'h00, 8'h00, 8'h00};
        for (k = 0; k < 600 && n_ack < 3; k++) begin
            @(negedge CLK);
            if (A_ACK) begin
                order[n_ack] = 0; rxs[n_ack] = A_RXD; n_ack++;
                if (A_TXD == 8'h3C) A_TXD = 8'h3D; else A_REQ = 1'b0;
            end else if (B_ACK) begin
                order[n_ack] = 1; rxs[n_ack] = B_RXD; n_ack++;
                B_REQ = 1'b0;
            end
            if (nCS) gap++;
            else begin
                if (n_ack > 0 && gap > 0 && gap < min_gap) min_gap = gap;
                gap = 0;
            end
        end
        check("sim_nack",   n_ack, 3);
        check("sim_own0",   order[0], 0);
        check("sim_own1",   order[1], 1);
        check("sim_own2",   order[2], 0);
        check("sim_rx0",    int'(rxs[0]), 'h3C);
        check("sim_rx1",    int'(rxs[1]), 'hC3);
        check("sim_rx2",    int'(rxs[2]), 'h3D);
        check("sim_gap_ok", int'(min_gap >= DIV && min_gap < 100), 1);
        A_REQ = 1'b0; B_REQ = 1'b0;
        wait_idle();

        // Locked burst 01/02/03 from A while B waits; the third request coincides with the HOLD drop
        do_reset();
        A_TXD = 8'h01; A_HOLD = 1'b1; A_REQ = 1'b1;
        B_TXD = 8'h77; B_HOLD = 1'b0; B_REQ = 1'b1;
        na = 0; b_early = 0; tb_ack = -1; ncs_hi = 0; busy_lo = 0; started = 1'b0;
        t_ack = '{0, 0, 0}; rxs = '{8'h00, 8'h00, 8'h00}; brx = 8'h00;
        for (k = 0; k < 800 && tb_ack < 0; k++) begin
            @(negedge CLK);
            if (A_ACK && na < 3) begin
                rxs[na] = A_RXD; t_ack[na] = cyc; na++;
                case (na)
                    1: A_TXD = 8'h02;
                    2: begin A_TXD = 8'h03; A_HOLD = 1'b0; end
                    default: A_REQ = 1'b0;
                endcase
            end
            if (B_ACK) begin
                if (na < 3) b_early++;
                tb_ack = cyc; brx = B_RXD; B_REQ = 1'b0;
            end
            if (!nCS) started = 1'b1;
            if (started && na < 3 && nCS)   ncs_hi++;
            if (started && na < 3 && !BUSY) busy_lo++;
        end
        check("lk_nack",   na, 3);
        check("lk_rx0",    int'(rxs[0]), 'h01);
        check("lk_rx1",    int'(rxs[1]), 'h02);
        check("lk_rx2",    int'(rxs[2]), 'h03);
        check("lk_int1",   t_ack[1] - t_ack[0], 33);
        check("lk_int2",   t_ack[2] - t_ack[1], 33);
        check("lk_ncs_hi", ncs_hi, 0);
        check("lk_busy",   busy_lo, 0);
        check("lk_bearly", b_early, 0);
        check("lk_b_lat",  (tb_ack >= 0) ? tb_ack - t_ack[2] : -1, 37);
        check("lk_b_rx",   int'(brx), 'h77);
        wait_idle();

        // Locked with no further request: bus stays held until HOLD drops, then deselects
        do_reset();
        A_TXD = 8'hE7; A_HOLD = 1'b1; A_REQ = 1'b1;
        for (k = 0; k < 200 && !A_ACK; k++) @(negedge CLK);
        check("hr_ack",  int'(A_ACK), 1);
        check("hr_rx",   int'(A_RXD), 'hE7);
        A_REQ = 1'b0;
        viol = 0;
        repeat (6) begin
            @(negedge CLK);
            if (nCS || !BUSY) viol++;
        end
        check("hr_held", viol, 0);
        A_HOLD = 1'b0;
        lat = -1;
        for (k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge CLK);
            if (nCS) lat = k;
        end
        check("hr_ncs_lat", lat, 1);
        lat = -1;
        for (k = 2; k <= 12 && lat < 0; k++) begin
            @(negedge CLK);
            if (!BUSY) lat = k;
        end
        check("hr_busy_lat", lat, 3);

        // Reset at the fourth SCK rise aborts the byte with no ACK
        do_reset();
        A_TXD = 8'h0F; A_REQ = 1'b1;
        rises = 0; reached = 1'b0; ps = SCK;
        for (k = 0; k < 200 && !reached; k++) begin
            @(negedge CLK);
            if (SCK && !ps) rises++;
            ps = SCK;
            if (rises == 4) reached = 1'b1;
        end
        check("mr_reached", int'(reached), 1);
        check("mr_sck_pre", int'(SCK), 1);
        nRESET = 1'b0;
        A_REQ = 1'b0;
        #1;
        check("mr_sck",  int'(SCK),  0);
        check("mr_mosi", int'(MOSI), 1);
        check("mr_ncs",  int'(nCS),  1);
        check("mr_busy", int'(BUSY), 0);
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;
        oth = 0;
        repeat (60) begin
            @(negedge CLK);
            if (A_ACK || B_ACK) oth++;
        end
        check("mr_no_ack", oth, 0);
        run_byte(1'b0, 8'hC5, lat, rx, rises, ack_w, oth);
        check("mr_rx",  int'(rx), 'hC5);
        check("mr_lat", lat, 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
